ternary_sampler_xs: RTL and testbench



---
 rtl/sntrup_pkg.sv | 28 ++
 rtl/xs_lane.sv | 40 ++++
 rtl/ternary_sampler_xs.sv | 102 ++++++++++
 tb/tb_ternary_sampler_xs.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sntrup_pkg.sv
// Shared constants, types and helper functions for the SNTRUP677
// small-polynomial sampling path.
package sntrup_pkg;

   localparam int unsigned P      = 677;
   localparam int unsigned COEF_W = 13;
   localparam logic [31:0] GOLDEN = 32'h9E3779B9;

   typedef logic signed [COEF_W-1:0] coef_t;

   typedef enum logic {StIdle, StRun} samp_state_e;

   function automatic logic [31:0] xorshift32_step(input logic [31:0] x);
      logic [31:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   // Top two bits of r*3 (18-bit product) give an almost uniform value in 0..2.
   function automatic coef_t ternary_map(input logic [15:0] r);
      logic [1:0] t;
      t = 2'(({2'b00, r} * 18'd3) >> 16);
      return coef_t'(signed'({1'b0, t}) - 3'sd1);
   endfunction

endpackage

// File: rtl/xs_lane.sv
// One xorshift32 lane: state register with seed load / step enables and
// a combinational ternary coefficient taken from the current state.
module xs_lane #(
   parameter int unsigned COEF_W = 13,
   parameter logic [31:0] INIT   = 32'h9E3779B9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [31:0]       seed,
   input  logic              step,
   output logic [COEF_W-1:0] coef
);
   import sntrup_pkg::*;

   logic [31:0] state_q, state_d;
   logic [31:0] seeded;

   always_comb begin
      state_d = state_q;
      seeded  = seed ^ INIT;
      // A zero state would lock xorshift at zero forever.
      if (load) begin
         state_d = (seeded == 32'h0) ? 32'h1 : seeded;
      end else if (step) begin
         state_d = xorshift32_step(state_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   assign coef = COEF_W'(ternary_map(state_q[15:0]));

endmodule

// File: rtl/ternary_sampler_xs.sv
// Handshaked ternary coefficient sampler: LANES xorshift32 lanes emit
// ceil(P/LANES) beats per polynomial with last-beat marking and tail masking.
module ternary_sampler_xs #(
   parameter int unsigned LANES  = 1,
   parameter int unsigned P      = sntrup_pkg::P,
   parameter int unsigned COEF_W = sntrup_pkg::COEF_W,
   parameter logic [31:0] GOLDEN = sntrup_pkg::GOLDEN
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    seed_load,
   input  logic [31:0]             seed,
   input  logic                    start,
   output logic                    coef_valid,
   input  logic                    coef_ready,
   output logic [LANES*COEF_W-1:0] coef_data,
   output logic                    coef_last,
   output logic                    busy,
   output logic                    done
);
   import sntrup_pkg::*;

   localparam int unsigned NB     = (P + LANES - 1) / LANES;
   localparam int unsigned CNT_W  = (NB > 1) ? $clog2(NB) : 1;
   localparam int unsigned LAST_N = P - (NB - 1) * LANES;

   samp_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             load, step, is_last;
   logic [COEF_W-1:0] lane_coef [LANES];

   assign is_last = (cnt_q == CNT_W'(NB - 1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (seed_load) begin
               load = 1'b1;
            end else if (start) begin
               step    = 1'b1;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (coef_ready) begin
               step = 1'b1;
               if (is_last) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign coef_valid = (state_q == StRun);
   assign busy       = (state_q == StRun);
   assign coef_last  = (state_q == StRun) && is_last;
   assign done       = done_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      xs_lane #(
         .COEF_W (COEF_W),
         .INIT   (32'(GOLDEN * 32'(i + 1)))
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load),
         .seed  (seed),
         .step  (step),
         .coef  (lane_coef[i])
      );
      // Lanes past the end of the polynomial read zero on the final beat.
      if (i >= LAST_N) begin : g_mask
         assign coef_data[i*COEF_W +: COEF_W] = coef_last ? '0 : lane_coef[i];
      end else begin : g_pass
         assign coef_data[i*COEF_W +: COEF_W] = lane_coef[i];
      end
   end

endmodule

// File: tb/tb_ternary_sampler_xs.sv
// Scoreboard bench for ternary_sampler_xs: a polynomial-level reference model
// fills an expected-beat queue; a negedge monitor pops and compares.
module tb_ternary_sampler_xs;
   localparam int          LANES  = 4;
   localparam int          P      = 677;
   localparam int          COEF_W = 13;
   localparam logic [31:0] GOLDEN = 32'h9E3779B9;
   localparam int          NB     = (P + LANES - 1) / LANES;
   localparam int          DW     = LANES * COEF_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          seed_load = 1'b0;
   logic [31:0]   seed = '0;
   logic          start = 1'b0;
   logic          coef_valid;
   logic          coef_ready = 1'b1;
   logic [DW-1:0] coef_data;
   logic          coef_last;
   logic          busy;
   logic          done;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t       sb[$];
   logic [31:0] m_lane[LANES];
   int          checks = 0;
   int          errors = 0;
   int          done_cnt = 0;
   int          beats_seen = 0;
   int          golden_left = 0;
   int          bp_mode = 0;

   ternary_sampler_xs #(
      .LANES  (LANES),
      .P      (P),
      .COEF_W (COEF_W),
      .GOLDEN (GOLDEN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seed_load  (seed_load),
      .seed       (seed),
      .start      (start),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .coef_data  (coef_data),
      .coef_last  (coef_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] xs(input logic [31:0] x);
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      return x;
   endfunction

   function automatic logic [COEF_W-1:0] tern(input logic [31:0] s);
      int unsigned t;
      t = ((s & 32'hFFFF) * 3) / 65536;
      return COEF_W'(int'(t) - 1);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LANES; i++) m_lane[i] = GOLDEN * (i + 1);
   endtask

   task automatic model_load(input logic [31:0] s);
      for (int i = 0; i < LANES; i++) begin
         m_lane[i] = s ^ (GOLDEN * (i + 1));
         if (m_lane[i] == 32'h0) m_lane[i] = 32'h1;
      end
   endtask

   // Whole polynomial: coefficient index b*LANES+i, zero once past P.
   task automatic model_run();
      beat_t e;
      for (int b = 0; b < NB; b++) begin
         for (int i = 0; i < LANES; i++) m_lane[i] = xs(m_lane[i]);
         e.data = '0;
         for (int i = 0; i < LANES; i++) begin
            if (b * LANES + i < P) e.data[i*COEF_W +: COEF_W] = tern(m_lane[i]);
         end
         e.last = (b == NB - 1);
         sb.push_back(e);
      end
      for (int i = 0; i < LANES; i++) m_lane[i] = xs(m_lane[i]);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         coef_ready = (bp_mode == 0) ? 1'b1 : ($urandom_range(99) >= 30);
      end
   end

   // Monitor
   initial begin
      logic          pend_done;
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      beat_t         e;
      pend_done  = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend_done  = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (done || pend_done) check("done_pulse", 64'(done), 64'(pend_done));
            if (done) done_cnt++;
            if (prev_stall) begin
               check("stall_valid", 64'(coef_valid), 64'd1);
               check("stall_data", 64'(coef_data), 64'(prev_data));
            end
            pend_done = 1'b0;
            if (coef_valid && coef_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %0h want none", coef_data);
               end else begin
                  e = sb.pop_front();
                  check("beat_data", 64'(coef_data), 64'(e.data));
                  check("beat_last", 64'(coef_last), 64'(e.last));
                  if (golden_left > 0) begin
                     check("golden_lane0", 64'(coef_data[COEF_W-1:0]), 64'h1FFF);
                     golden_left--;
                  end
                  pend_done = e.last;
               end
               beats_seen++;
            end
            prev_stall = coef_valid && !coef_ready;
            prev_data  = coef_data;
         end
      end
   end

   task automatic load(input logic [31:0] s);
      seed      = s;
      seed_load = 1'b1;
      cyc(1);
      seed_load = 1'b0;
      model_load(s);
   endtask

   task automatic run(input bit mid_ctrl);
      int d0;
      start = 1'b1;
      model_run();
      cyc(1);
      start = 1'b0;
      check("latency_valid", 64'(coef_valid), 64'd1);
      check("busy_run", 64'(busy), 64'd1);
      d0 = done_cnt;
      for (int k = 0; k < 4000; k++) begin
         if (done_cnt != d0) break;
         if (mid_ctrl && k == 20) begin
            start     = 1'b1;
            seed_load = 1'b1;
            seed      = $urandom;
         end
         if (mid_ctrl && k == 21) begin
            start     = 1'b0;
            seed_load = 1'b0;
         end
         cyc(1);
      end
      cyc(3);
      check("done_once", 64'(done_cnt - d0), 64'd1);
      check("idle_after", 64'(busy), 64'd0);
      check("queue_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      logic [31:0] s;
      int          b0;
      cyc(3);
      check("rst_valid", 64'(coef_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      cyc(1);

      // Reset lane values drive the very first polynomial.
      model_reset();
      run(1'b0);

      load(32'h9E3779B8);
      golden_left = 2;
      run(1'b0);

      // Seed equal to GOLDEN zeroes lane 0, which must be forced to 1.
      load(GOLDEN);
      golden_left = 2;
      run(1'b0);

      bp_mode = 1;
      load(32'h12345678);
      run(1'b0);
      bp_mode = 0;
      load(32'h12345678);
      run(1'b0);
      run(1'b0);

      bp_mode = 1;
      run(1'b1);
      bp_mode = 0;

      // seed_load with start in IDLE: load only.
      s         = $urandom;
      seed      = s;
      seed_load = 1'b1;
      start     = 1'b1;
      cyc(1);
      seed_load = 1'b0;
      start     = 1'b0;
      model_load(s);
      cyc(2);
      check("load_prio_busy", 64'(busy), 64'd0);
      check("load_prio_valid", 64'(coef_valid), 64'd0);
      run(1'b0);

      // Asynchronous reset partway through a polynomial.
      s = 32'hCAFEF00D;
      load(s);
      b0    = beats_seen;
      start = 1'b1;
      model_run();
      cyc(1);
      start = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         if (beats_seen - b0 >= 50) break;
         cyc(1);
      end
      check("reached_beat50", 64'(beats_seen - b0 >= 50), 64'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_valid", 64'(coef_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_last", 64'(coef_last), 64'd0);
      sb.delete();
      model_reset();
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      load(s);
      run(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
